pipe_elastic_stage: RTL and testbench
=====================================

Name: pipe_elastic_stage

Overview:
- Parametrised, hazard-aware elastic pipeline stage for the CPU datapath. It is the next generation of the single-register inter-stage pipe.
- Holds up to DEPTH in-flight entries of WIDTH bits each, with valid/ready handshakes on both sides.
- Honours the core's hazard codes (`FLUSH_ALL`, `FLUSH_EARLY`, `STALL_MMU`, taken from the shared instruction defines header).
- Sits between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB), selected by STAGE.

Parameters:
- STAGE, `STAGE_ID, pipeline stage this instance feeds; selects which flush codes apply.
- WIDTH, 32, payload width in bits (>=1).
- DEPTH, 2, number of buffer entries (>=1; any value, not limited to powers of two).
- RESET_VALUE, 0, value driven on out_data whenever the buffer is empty.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- hazard_signal  in  4  hazard code from the hazard unit.
- in_valid  in  1  upstream payload valid.
- in_ready  out  1  stage can accept a payload this cycle.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  head entry presented downstream.
- out_ready  in  1  downstream accepts the head entry.
- out_data  out  WIDTH  head payload, or RESET_VALUE when empty.
- occupancy  out  $clog2(DEPTH+1)  number of valid entries.

Behaviour:
- Storage is a circular buffer with write pointer, read pointer and count.
  - Pointers are $clog2(DEPTH) bits (minimum 1) and wrap from DEPTH-1 to 0 explicitly.
  - Power-of-two rollover is not relied on.
- flush_hit is true when any of the following holds:
  - hazard_signal==`FLUSH_ALL and STAGE!=`STAGE_WB;
  - hazard_signal==`FLUSH_EARLY and STAGE==`STAGE_ID.
- stall is true when hazard_signal==`STALL_MMU and flush_hit is false.
- Reset, or flush_hit, at a clock edge:
  - count, write pointer and read pointer are cleared to 0;
  - any upstream beat in that cycle is discarded;
  - the head is not consumed.
  - Reset has priority over everything; flush has priority over stall and handshakes.
- After reset: out_valid=0, out_data=RESET_VALUE, occupancy=0. in_ready=1 in the cycle after reset deasserts.
- in_ready = (count<DEPTH) and not stall and not flush_hit.
  - It is combinational on count and hazard_signal only, never on out_ready.
  - When full, a same-cycle dequeue does not open a slot.
- out_valid = (count!=0) and not stall and not flush_hit.
- out_data = mem[read pointer] when count!=0, else RESET_VALUE. Stall and flush do not change out_data combinationally.
- Enqueue fires when in_valid and in_ready:
  - mem[write pointer] <= in_data;
  - the write pointer advances.
- Dequeue fires when out_valid and out_ready: the read pointer advances.
- Count update when both fire in the same cycle: count unchanged (only possible when 0<count<DEPTH). Otherwise count is +1 on enqueue and -1 on dequeue.
- Latency: a beat accepted at edge N is visible on out_valid/out_data after edge N. Minimum latency is 1 cycle.
- Throughput: 1 beat/cycle sustained when DEPTH>=2. With DEPTH=1, at most 1 beat every 2 cycles.
- Stall (`STALL_MMU`) freezes all state: no enqueue, no dequeue, contents and pointers held. The handshake resumes in the first cycle hazard_signal leaves `STALL_MMU`.
- Any other hazard code (including 0) is normal operation.
- Payload ordering is strict FIFO. No entry is duplicated or lost except by flush or reset.

Optional Feature:
- Macro PIPE_ELASTIC_BYPASS_EN.
- Defined: when count==0, in_valid=1, out_ready=1, no stall and no flush_hit:
  - in_data is forwarded combinationally to out_data with out_valid=1 (0-cycle latency);
  - the beat is not written; count stays 0;
  - in_ready is 1 and the handshake completes on both sides.
- Defined, count==0, out_ready=0: the beat is enqueued as normal.
- Not defined: no combinational in-to-out path; minimum latency is 1 cycle as above.

Test Plan:
- Reset then idle, DEPTH=2: rst=1 for 2 cycles -> out_valid=0, out_data=0, occupancy=0, in_ready=1 after release.
- Fill and drain, DEPTH=3, out_ready=0, push 0xA1,0xA2,0xA3,0xA4 -> 3 accepted, in_ready=0 at occupancy=3, 0xA4 held upstream. Then out_ready=1 -> outputs 0xA1,0xA2,0xA3,0xA4 in order; pointers wrap correctly.
- Simultaneous enqueue/dequeue, occupancy=1, push 0xB0 while popping 0xAF -> occupancy stays 1, next out_data=0xB0.
- Stall, occupancy=2, hazard_signal=`STALL_MMU for 3 cycles with in_valid=1, out_ready=1 -> in_ready=0, out_valid=0, occupancy=2 throughout; afterwards the original order resumes.
- Flush:
  - STAGE=`STAGE_ID, occupancy=2, `FLUSH_EARLY with in_valid=1 -> next cycle occupancy=0, out_data=RESET_VALUE, input beat dropped.
  - Same instance with STAGE=`STAGE_WB under `FLUSH_ALL -> contents unaffected.
- Flush during stall: hazard_signal=`FLUSH_ALL, STAGE=`STAGE_EX -> cleared. With PIPE_ELASTIC_BYPASS_EN, empty, in 0x5 and out_ready=1 -> out_data=0x5 in the same cycle, occupancy stays 0.

Source files
------------

// File: rtl/pipe_elastic_stage.sv
// pipe_elastic_stage: hazard-aware elastic FIFO stage placed between two CPU pipeline stages.
// Optional zero-latency empty-buffer bypass is built when PIPE_ELASTIC_BYPASS_EN is defined.

`ifndef FLUSH_ALL
`define FLUSH_ALL   4'd1
`endif
`ifndef FLUSH_EARLY
`define FLUSH_EARLY 4'd2
`endif
`ifndef STALL_MMU
`define STALL_MMU   4'd3
`endif
`ifndef STAGE_IF
`define STAGE_IF    0
`endif
`ifndef STAGE_ID
`define STAGE_ID    1
`endif
`ifndef STAGE_EX
`define STAGE_EX    2
`endif
`ifndef STAGE_MEM
`define STAGE_MEM   3
`endif
`ifndef STAGE_WB
`define STAGE_WB    4
`endif

module pipe_elastic_stage #(
  parameter int               STAGE       = `STAGE_ID,
  parameter int               WIDTH       = 32,
  parameter int               DEPTH       = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [3:0]                 hazard_signal,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);
  localparam int              PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int              CW   = $clog2(DEPTH + 1);
  localparam logic [PW-1:0]   LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0]   FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             flush_hit, stall, byp, enq, deq, empty;

  // Explicit wrap so non-power-of-two depths never index past the last entry.
  function automatic logic [PW-1:0] ptr_nxt(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign flush_hit = ((hazard_signal == `FLUSH_ALL)   && (STAGE != `STAGE_WB)) ||
                     ((hazard_signal == `FLUSH_EARLY) && (STAGE == `STAGE_ID));
  assign stall     = (hazard_signal == `STALL_MMU) && !flush_hit;
  assign empty     = (count == '0);

`ifdef PIPE_ELASTIC_BYPASS_EN
  assign byp = empty && in_valid && out_ready && !stall && !flush_hit;
`else
  assign byp = 1'b0;
`endif

  // Ready depends only on count and hazard; a full buffer never borrows the slot being drained.
  assign in_ready  = (count != FULL) && !stall && !flush_hit;
  assign out_valid = (!empty || byp) && !stall && !flush_hit;
  assign occupancy = count;

  // A bypassed beat completes both handshakes without touching storage.
  assign enq = in_valid && in_ready && !byp;
  assign deq = out_valid && out_ready && !byp;

  always_comb begin
    out_data = RESET_VALUE;
    if (!empty)   out_data = mem[rd_ptr];
    else if (byp) out_data = in_data;
  end

  always_ff @(posedge clk) begin
    if (!rst && enq) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst || flush_hit) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= ptr_nxt(wr_ptr);
      if (deq) rd_ptr <= ptr_nxt(rd_ptr);
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_elastic_stage.sv
// Directed bench for pipe_elastic_stage: four instances share stimulus; the DEPTH=3 STAGE_ID
// instance is tracked by a FIFO scoreboard, the others by directed expectations.

`ifndef FLUSH_ALL
`define FLUSH_ALL   4'd1
`endif
`ifndef FLUSH_EARLY
`define FLUSH_EARLY 4'd2
`endif
`ifndef STALL_MMU
`define STALL_MMU   4'd3
`endif
`ifndef STAGE_ID
`define STAGE_ID    1
`endif
`ifndef STAGE_EX
`define STAGE_EX    2
`endif
`ifndef STAGE_WB
`define STAGE_WB    4
`endif

module tb_pipe_elastic_stage;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] hz;
  logic       in_valid, out_ready;
  logic [7:0] in_data;

  logic       d2_ir, d2_ov, d3_ir, d3_ov, wb_ir, wb_ov, ex_ir, ex_ov;
  logic [7:0] d2_od, d3_od, wb_od, ex_od;
  logic [1:0] d2_occ, d3_occ, wb_occ, ex_occ;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] sb [$];
  logic [7:0] exp_d;

  always #5 clk = ~clk;

  pipe_elastic_stage #(.STAGE(`STAGE_ID), .WIDTH(8), .DEPTH(2), .RESET_VALUE(8'h00)) u_d2 (
    .clk(clk), .rst(rst), .hazard_signal(hz), .in_valid(in_valid), .in_ready(d2_ir),
    .in_data(in_data), .out_valid(d2_ov), .out_ready(out_ready), .out_data(d2_od), .occupancy(d2_occ));
  pipe_elastic_stage #(.STAGE(`STAGE_ID), .WIDTH(8), .DEPTH(3), .RESET_VALUE(8'hEE)) u_d3 (
    .clk(clk), .rst(rst), .hazard_signal(hz), .in_valid(in_valid), .in_ready(d3_ir),
    .in_data(in_data), .out_valid(d3_ov), .out_ready(out_ready), .out_data(d3_od), .occupancy(d3_occ));
  pipe_elastic_stage #(.STAGE(`STAGE_WB), .WIDTH(8), .DEPTH(3), .RESET_VALUE(8'h00)) u_wb (
    .clk(clk), .rst(rst), .hazard_signal(hz), .in_valid(in_valid), .in_ready(wb_ir),
    .in_data(in_data), .out_valid(wb_ov), .out_ready(out_ready), .out_data(wb_od), .occupancy(wb_occ));
  pipe_elastic_stage #(.STAGE(`STAGE_EX), .WIDTH(8), .DEPTH(3), .RESET_VALUE(8'h00)) u_ex (
    .clk(clk), .rst(rst), .hazard_signal(hz), .in_valid(in_valid), .in_ready(ex_ir),
    .in_data(in_data), .out_valid(ex_ov), .out_ready(out_ready), .out_data(ex_od), .occupancy(ex_occ));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs after the falling edge, then settle and update the scoreboard.
  task automatic step(input logic r, input logic [3:0] h, input logic iv,
                      input logic [7:0] d, input logic ordy);
    @(negedge clk);
    rst = r; hz = h; in_valid = iv; in_data = d; out_ready = ordy;
    #1;
    if (r || h == `FLUSH_ALL || h == `FLUSH_EARLY) begin
      sb.delete();
    end else begin
      if (iv && d3_ir) sb.push_back(d);
      if (d3_ov && ordy) begin
        n_cmp++;
        assert (sb.size() > 0) else begin
          n_bad++;
          $error("FAIL sb_underflow observed_data=%0h expected=queued_entry", d3_od);
        end
        if (sb.size() > 0) begin
          exp_d = sb.pop_front();
          chk("sb_data", 32'(d3_od), 32'(exp_d));
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; hz = 4'd0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;

    // Reset then idle
    step(1, 0, 0, 8'h00, 0);
    step(1, 0, 0, 8'h00, 0);
    step(0, 0, 0, 8'h00, 0);
    chk("rst_d2_ov", d2_ov, 0);   chk("rst_d2_od", d2_od, 8'h00);
    chk("rst_d2_occ", d2_occ, 0); chk("rst_d2_ir", d2_ir, 1);
    chk("rst_d3_od", d3_od, 8'hEE);

    // Fill DEPTH=3 with the consumer blocked
    step(0, 0, 1, 8'hA1, 0); chk("fill_ir0", d3_ir, 1); chk("fill_occ0", d3_occ, 0);
    step(0, 0, 1, 8'hA2, 0); chk("fill_occ1", d3_occ, 1);
    step(0, 0, 1, 8'hA3, 0); chk("fill_occ2", d3_occ, 2); chk("fill_ir2", d3_ir, 1);
    step(0, 0, 1, 8'hA4, 0); chk("full_occ", d3_occ, 3); chk("full_ir", d3_ir, 0);
    chk("full_ov", d3_ov, 1); chk("full_od", d3_od, 8'hA1);
    chk("d2_full_ir", d2_ir, 0); chk("d2_full_occ", d2_occ, 2);

    // Drain; full buffer must not accept on the dequeue cycle
    step(0, 0, 1, 8'hA4, 1); chk("full_deq_ir", d3_ir, 0);
    step(0, 0, 1, 8'hA4, 1); chk("drain_ir", d3_ir, 1); chk("drain_occ", d3_occ, 2);
    step(0, 0, 0, 8'h00, 1);
    step(0, 0, 0, 8'h00, 1); chk("wrap_od", d3_od, 8'hA4);
    step(0, 0, 0, 8'h00, 0);
    chk("empty_ov", d3_ov, 0); chk("empty_od", d3_od, 8'hEE); chk("empty_occ", d3_occ, 0);

    // Simultaneous enqueue/dequeue at occupancy 1
    step(0, 0, 1, 8'hAF, 0);
    step(0, 0, 1, 8'hB0, 1); chk("sim_occ_pre", d3_occ, 1);
    step(0, 0, 0, 8'h00, 0); chk("sim_occ", d3_occ, 1); chk("sim_od", d3_od, 8'hB0);

    // Stall with two entries held
    step(0, 0, 1, 8'hB1, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, `STALL_MMU, 1, 8'hB2, 1);
      chk("stall_ir", d3_ir, 0); chk("stall_ov", d3_ov, 0);
      chk("stall_occ", d3_occ, 2); chk("stall_od", d3_od, 8'hB0);
    end
    step(0, 0, 0, 8'h00, 1); chk("unstall_ov", d3_ov, 1); chk("unstall_od", d3_od, 8'hB0);
    step(0, 0, 0, 8'h00, 1); chk("unstall_od2", d3_od, 8'hB1);
    step(0, 0, 0, 8'h00, 0); chk("unstall_occ", d3_occ, 0);

    // Flush: FLUSH_EARLY clears ID only, FLUSH_ALL clears all but WB
    step(1, 0, 0, 8'h00, 0);
    step(0, 0, 1, 8'hC1, 0); chk("fl_occ0", d3_occ, 0);
    step(0, 0, 1, 8'hC2, 0);
    step(0, `FLUSH_EARLY, 1, 8'hC3, 1);
    chk("fe_ir", d3_ir, 0); chk("fe_ov", d3_ov, 0); chk("fe_occ", d3_occ, 2);
    chk("fe_od", d3_od, 8'hC1); chk("fe_wb_ir", wb_ir, 1); chk("fe_wb_ov", wb_ov, 1);
    step(0, `FLUSH_ALL, 1, 8'hC4, 1);
    chk("fe_d3_occ", d3_occ, 0); chk("fe_d3_od", d3_od, 8'hEE);
    chk("fe_d2_occ", d2_occ, 0); chk("fe_d2_od", d2_od, 8'h00);
    chk("fa_d3_ir", d3_ir, 0);
    chk("fa_wb_ir", wb_ir, 1); chk("fa_wb_ov", wb_ov, 1); chk("fa_wb_od", wb_od, 8'hC2);
    chk("fa_wb_occ", wb_occ, 2);
    chk("fa_ex_ir", ex_ir, 0); chk("fa_ex_ov", ex_ov, 0); chk("fa_ex_occ", ex_occ, 2);
    step(0, 0, 0, 8'h00, 0);
    chk("fa_wb_occ2", wb_occ, 2); chk("fa_wb_od2", wb_od, 8'hC3);
    chk("fa_ex_cleared", ex_occ, 0); chk("fa_ex_ov2", ex_ov, 0); chk("fa_d3_occ", d3_occ, 0);

    // Empty buffer with consumer ready
    step(0, 0, 1, 8'h05, 1);
`ifdef PIPE_ELASTIC_BYPASS_EN
    chk("byp_ov", d3_ov, 1); chk("byp_od", d3_od, 8'h05);
    chk("byp_ir", d3_ir, 1); chk("byp_occ", d3_occ, 0);
    step(0, 0, 0, 8'h00, 1); chk("byp_occ2", d3_occ, 0); chk("byp_ov2", d3_ov, 0);
`else
    chk("lat_ov", d3_ov, 0); chk("lat_od", d3_od, 8'hEE); chk("lat_ir", d3_ir, 1);
    step(0, 0, 0, 8'h00, 1); chk("lat_ov1", d3_ov, 1); chk("lat_od1", d3_od, 8'h05);
    chk("lat_occ1", d3_occ, 1);
    step(0, 0, 0, 8'h00, 0); chk("lat_occ2", d3_occ, 0);
`endif

    chk("sb_left", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
